serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial unsigned subtractor with a three-state controller.
//            Computes diff = a - b (mod 2^WIDTH) LSB first, one bit per clock,
//            and reports the final borrow (set exactly when a < b).
// Ports    : clk        - clock, all state updates on the rising edge
//            rst_n      - asynchronous active-low reset
//            start      - request; accepted only in IDLE when abort is low
//            abort      - cancels an operation in RUN
//            a, b       - minuend / subtrahend, captured at acceptance
//            busy       - high while in RUN
//            done       - one-cycle pulse when diff/borrow_out are fresh
//            diff       - result register (never shows partial results)
//            borrow_out - final borrow of the last completed operation
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter only needs to reach WIDTH-1: the last RUN edge is detected by
    // comparison rather than by counting up to WIDTH.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_br;

    logic             w_hs1_d;
    logic             w_hs1_br;
    logic             w_d;
    logic             w_hs2_br;
    logic             w_br_next;
    logic [WIDTH-1:0] w_acc_next;

    // Full subtractor built from two half subtractors:
    //   stage 1: a_i - b_i, stage 2: (stage1 result) - borrow_in.
    always_comb begin
        w_hs1_d    = r_a_sh[0] ^ r_b_sh[0];
        w_hs1_br   = ~r_a_sh[0] & r_b_sh[0];
        w_d        = w_hs1_d ^ r_br;
        w_hs2_br   = ~w_hs1_d & r_br;
        w_br_next  = w_hs1_br | w_hs2_br;
        // Result bits enter at the top; after WIDTH shifts bit 0 sits at LSB.
        w_acc_next = {w_d, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_br       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    // abort wins over start: no acceptance while it is high
                    if (start && !abort) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_br    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Drop the operation; result registers keep old value.
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_a_sh <= r_a_sh >> 1;
                        r_b_sh <= r_b_sh >> 1;
                        r_acc  <= w_acc_next;
                        r_br   <= w_br_next;
                        r_cnt  <= r_cnt + C_ONE;
                        if (r_cnt == C_LAST) begin
                            diff       <= w_acc_next;
                            borrow_out <= w_br_next;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Purpose  : Self-checking bench for serial_sub_ctrl (WIDTH = 8). A reference
//            model predicts each accepted operation's result into a
//            scoreboard; a monitor checks busy/done timing, result values,
//            result hold behaviour and reset values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;
    localparam int QSZ   = 4096;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (written only here) ----------------
    // remain: cycles left until back in IDLE; >1 means RUN, ==1 means DONE.
    int               remain = 0;
    int               wr = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] exp_diff [QSZ];
    logic             exp_br   [QSZ];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (remain > 1) wr = wr - 1;   // pending operation is discarded
            remain = 0;
        end else begin
            cyc = cyc + 1;
            if (remain == 0) begin
                if (start && !abort) begin
                    exp_diff[wr % QSZ] = WIDTH'(int'(a) - int'(b));
                    exp_br[wr % QSZ]   = (a < b);
                    wr     = wr + 1;
                    remain = WIDTH + 1;
                end
            end else if (remain > 1) begin
                if (abort) begin
                    wr     = wr - 1;
                    remain = 0;
                end else begin
                    remain = remain - 1;
                end
            end else begin
                remain = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard checker ----------------
    int               n_chk = 0;
    int               n_pass = 0;
    int               rd = 0;
    int               last_done = -1000;
    logic [WIDTH-1:0] held_diff = '0;
    logic             held_br = 1'b0;
    logic             mon_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        while (!mon_stop) begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                held_diff = '0;
                held_br   = 1'b0;
                last_done = -1000;
                chk("reset_busy", {31'd0, busy}, 32'd0);
                chk("reset_done", {31'd0, done}, 32'd0);
                chk("reset_diff", {24'd0, diff}, 32'd0);
                chk("reset_borrow", {31'd0, borrow_out}, 32'd0);
            end else begin
                chk("busy", {31'd0, busy}, {31'd0, remain > 1});
                chk("done", {31'd0, done}, {31'd0, remain == 1});
                if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
                if (done) begin
                    if (rd >= wr) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        held_diff = exp_diff[rd % QSZ];
                        held_br   = exp_br[rd % QSZ];
                        rd = rd + 1;
                        chk("done_spacing_ge10", {31'd0, (cyc - last_done) >= 10}, 32'd1);
                        last_done = cyc;
                    end
                end
                chk("diff", {24'd0, diff}, {24'd0, held_diff});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, held_br});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
        repeat (WIDTH + 2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(8'h5A, 8'h23);
        op(8'h23, 8'h5A);
        op(8'h00, 8'h01);
        op(8'hFF, 8'hFF);

        // start re-pulsed and operands changed while running
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h7E;
        repeat (3) @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'hFF;
        repeat (WIDTH + 4) @(negedge clk);

        // abort sampled on the edge that would process bit 3
        @(negedge clk);
        a = 8'h77; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);

        // asynchronous reset in the middle of RUN (after bit 3, during bit 4)
        @(negedge clk);
        a = 8'h9C; b = 8'h21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clk);

        // first start after reset is accepted normally
        op(8'h01, 8'h80);

        // randomized traffic with random spacing, held start and rare aborts
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 7))
                0: begin a = 8'h00; b = WIDTH'($urandom); end
                1: begin a = 8'hFF; b = WIDTH'($urandom); end
                2: begin a = WIDTH'($urandom); b = a; end
                default: begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
            endcase
        end
        start = 1'b0;
        abort = 1'b0;

        // bounded drain of the scoreboard
        for (int i = 0; i < 3 * WIDTH && rd != wr; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", rd, wr);
        chk("ops_completed_min", {31'd0, rd > 1000}, 32'd1);
        mon_stop = 1'b1;
        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
